// File: rtl/seven_segment_scan_ctrl.sv
// Four-digit multiplexed common-anode 7-segment driver with frame-synchronous
// double buffering, anti-ghosting guard time and optional leading-zero blanking.
module seven_segment_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GUARD       = 16,
    parameter int unsigned CNT_W       = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        pending,
    output logic        frame_done
);

    localparam logic [0:0] ST_GUARD = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
    localparam logic [3:0]       AN_OFF    = 4'b1111;
    localparam logic [6:0]       SEG_OFF   = 7'b1111111;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [15:0]      active;
    logic [15:0]      pend_val;

    logic [0:0]       slot_state_c;
    logic             boundary_c;
    logic [3:0]       digit_c;
    logic             blank_c;
    logic [3:0]       an_next_c;
    logic [6:0]       seg_next_c;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0001100;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    // Slot timebase: cnt walks one slot, idx walks the four digits of a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Slot state, digit selection and next display pattern.
    always_comb begin
        slot_state_c = ST_GUARD;
        boundary_c   = 1'b0;
        digit_c      = 4'd0;
        blank_c      = 1'b0;
        an_next_c    = AN_OFF;
        seg_next_c   = SEG_OFF;

        if (cnt >= CNT_GUARD) begin
            slot_state_c = ST_DRIVE;
        end
        boundary_c = (idx == 2'd3) && (cnt == CNT_LAST);

        case (idx)
            2'd0: begin
                digit_c = active[3:0];
                blank_c = 1'b0;
            end
            2'd1: begin
                digit_c = active[7:4];
                blank_c = blank_lz && (active[15:4] == 12'd0);
            end
            2'd2: begin
                digit_c = active[11:8];
                blank_c = blank_lz && (active[15:8] == 8'd0);
            end
            default: begin
                digit_c = active[15:12];
                blank_c = blank_lz && (active[15:12] == 4'd0);
            end
        endcase

        case (slot_state_c)
            ST_DRIVE: begin
                if (!blank_c) begin
                    an_next_c  = ~(4'b0001 << idx);
                    seg_next_c = decode(digit_c);
                end
            end
            default: begin
                an_next_c  = AN_OFF;
                seg_next_c = SEG_OFF;
            end
        endcase
    end

    // Registered pin drive and end-of-frame pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            an         <= an_next_c;
            seg        <= seg_next_c;
            frame_done <= boundary_c;
        end
    end

    // Double buffer: a load on the boundary itself bypasses the pending register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active   <= 16'd0;
            pend_val <= 16'd0;
            pending  <= 1'b0;
        end else if (boundary_c) begin
            if (load) begin
                active <= value;
            end else if (pending) begin
                active <= pend_val;
            end
            pending <= 1'b0;
        end else if (load) begin
            pend_val <= value;
            pending  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Self-checking bench for seven_segment_scan_ctrl: a frame-level model predicts
// every output cycle by cycle while directed and random loads are applied.
module tb_seven_segment_scan_ctrl;

    localparam int RD = 8;
    localparam int G  = 2;
    localparam int FRAME = 4 * RD;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        pending;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seven_segment_scan_ctrl #(
        .REFRESH_DIV(RD),
        .GUARD      (G),
        .CNT_W      (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .load      (load),
        .blank_lz  (blank_lz),
        .an        (an),
        .seg       (seg),
        .pending   (pending),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_lut [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b1111111, 7'b1111111,
        7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
    };

    // Reference model state: cyc counts clock edges since reset release.
    int          cyc;
    logic [15:0] m_active;
    logic [15:0] m_pend;
    logic        m_pending;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_fd;

    function automatic logic [10:0] model_disp(input int k, input logic [15:0] act, input logic blz);
        int          pos;
        int          slot;
        logic [15:0] upper;
        logic [3:0]  a;
        pos   = k % RD;
        slot  = (k / RD) % 4;
        upper = act >> (4 * slot);
        if (pos < G || (blz && slot != 0 && upper == 16'd0)) return {4'hF, 7'h7F};
        a = ~(4'(1) << slot);
        return {a, seg_lut[upper[3:0]]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc       <= 0;
            m_active  <= 16'd0;
            m_pend    <= 16'd0;
            m_pending <= 1'b0;
            e_an      <= 4'hF;
            e_seg     <= 7'h7F;
            e_fd      <= 1'b0;
        end else begin
            {e_an, e_seg} <= model_disp(cyc, m_active, blank_lz);
            e_fd <= (cyc % FRAME) == FRAME - 1;
            if ((cyc % FRAME) == FRAME - 1) begin
                if (load) m_active <= value;
                else if (m_pending) m_active <= m_pend;
                m_pending <= 1'b0;
            end else if (load) begin
                m_pend    <= value;
                m_pending <= 1'b1;
            end
            cyc <= cyc + 1;
        end
    end

    task automatic pulse_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < FRAME && (cyc % FRAME) != p; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        int fd_count;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({an, seg, pending, frame_done} !== {4'hF, 7'h7F, 2'b00}) begin
                errors++;
                $display("FAIL reset_hold got an=%b seg=%b pend=%b fd=%b want 1111/1111111/0/0",
                         an, seg, pending, frame_done);
            end
        end
        rst = 1'b0;
        fd_count = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (frame_done) fd_count++;
            checks++;
            if ({an, seg, pending, frame_done} !== {e_an, e_seg, m_pending, e_fd}) begin
                errors++;
                $display("FAIL idle cyc=%0d got %b/%b/%b/%b want %b/%b/%b/%b",
                         cyc, an, seg, pending, frame_done, e_an, e_seg, m_pending, e_fd);
            end
            if (i == G) begin
                checks++;
                if ({an, seg} !== {4'b1110, 7'b0000001}) begin
                    errors++;
                    $display("FAIL first_drive got an=%b seg=%b want 1110/0000001", an, seg);
                end
            end
        end
        checks++;
        if (fd_count !== 2) begin
            errors++;
            $display("FAIL frame_done_rate got %0d pulses want 2", fd_count);
        end
    endtask

    task automatic test_scan;
        blank_lz = 1'b0;
        pulse_load(16'h1234);
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, pending, frame_done} !== {e_an, e_seg, m_pending, e_fd}) begin
                errors++;
                $display("FAIL scan cyc=%0d got %b/%b/%b/%b want %b/%b/%b/%b",
                         cyc, an, seg, pending, frame_done, e_an, e_seg, m_pending, e_fd);
            end
        end
    endtask

    task automatic test_deferred;
        wait_pos(10);
        pulse_load(16'h5678);
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL deferred_pending got %b want 1", pending);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, pending, frame_done} !== {e_an, e_seg, m_pending, e_fd}) begin
                errors++;
                $display("FAIL deferred cyc=%0d got %b/%b/%b/%b want %b/%b/%b/%b",
                         cyc, an, seg, pending, frame_done, e_an, e_seg, m_pending, e_fd);
            end
        end
    endtask

    task automatic test_race;
        wait_pos(5);
        pulse_load(16'h1111);
        wait_pos(FRAME - 1);
        pulse_load(16'h2222);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, pending, frame_done} !== {e_an, e_seg, m_pending, e_fd}) begin
                errors++;
                $display("FAIL race cyc=%0d got %b/%b/%b/%b want %b/%b/%b/%b",
                         cyc, an, seg, pending, frame_done, e_an, e_seg, m_pending, e_fd);
            end
            checks++;
            if (an !== 4'hF && seg === 7'b1001111) begin
                errors++;
                $display("FAIL race_stale got an=%b seg=%b want no digit 1 shown", an, seg);
            end
        end
    endtask

    task automatic test_blank;
        logic [15:0] vals [3] = '{16'h0070, 16'h0000, 16'h00A5};
        blank_lz = 1'b1;
        foreach (vals[j]) begin
            pulse_load(vals[j]);
            for (int i = 0; i < 2 * FRAME; i++) begin
                @(negedge clk);
                checks++;
                if ({an, seg, pending, frame_done} !== {e_an, e_seg, m_pending, e_fd}) begin
                    errors++;
                    $display("FAIL blank v=%h cyc=%0d got %b/%b/%b/%b want %b/%b/%b/%b",
                             vals[j], cyc, an, seg, pending, frame_done, e_an, e_seg, m_pending, e_fd);
                end
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_reset_mid;
        wait_pos(5);
        pulse_load(16'h4321);
        wait_pos(2 * RD + G + 1);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({an, seg, pending} !== {4'hF, 7'h7F, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid got an=%b seg=%b pend=%b want 1111/1111111/0", an, seg, pending);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, pending, frame_done} !== {e_an, e_seg, m_pending, e_fd}) begin
                errors++;
                $display("FAIL after_reset cyc=%0d got %b/%b/%b/%b want %b/%b/%b/%b",
                         cyc, an, seg, pending, frame_done, e_an, e_seg, m_pending, e_fd);
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 1500; i++) begin
            load  = ($urandom_range(0, 19) == 0);
            value = 16'($urandom);
            if ($urandom_range(0, 99) == 0) blank_lz = ~blank_lz;
            @(negedge clk);
            checks++;
            if ({an, seg, pending, frame_done} !== {e_an, e_seg, m_pending, e_fd}) begin
                errors++;
                $display("FAIL random cyc=%0d got %b/%b/%b/%b want %b/%b/%b/%b",
                         cyc, an, seg, pending, frame_done, e_an, e_seg, m_pending, e_fd);
            end
        end
        load = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        value    = 16'd0;
        load     = 1'b0;
        blank_lz = 1'b0;
        test_reset;
        test_scan;
        test_deferred;
        test_race;
        test_blank;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_segment_scan_ctrl.md
Name: seven_segment_scan_ctrl

Overview:
- Time-multiplexes a 4-digit BCD value onto one shared common-anode 7-segment bus.
- Drives an active-low anode per digit and an active-low segment pattern.
- Double-buffers the displayed value so updates land only at frame boundaries, with no tearing.
- Sits between the counter/datapath producing BCD digits and the board display pins.

Parameters:
- REFRESH_DIV, 100000: clocks per digit slot; legal minimum is GUARD+2.
- GUARD, 16: clocks at the start of each slot with all anodes off, to suppress ghosting; must be ≥1 and < REFRESH_DIV.
- CNT_W, 17: width of the slot counter; must hold REFRESH_DIV-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- value  in  16  four BCD digits; [3:0] is digit0, the rightmost.
- load  in  1  one-cycle strobe that captures value into the pending register.
- blank_lz  in  1  1 = blank leading zeros.
- an  out  4  anode enables, active-low; an[i] selects digit i.
- seg  out  7  segments, active-low; [6]=a, [5]=b, [4]=c, [3]=d, [2]=e, [1]=f, [0]=g.
- pending  out  1  a loaded value is waiting for the next frame boundary.
- frame_done  out  1  one-cycle pulse after digit3's slot ends.

Behaviour:
- Reset (async assert, sync release):
  - cnt=0, idx=0, active=0, pend_val=0.
  - Outputs: pending=0, frame_done=0, an=4'b1111, seg=7'b1111111.
- Slot counter: cnt increments each clock; at cnt==REFRESH_DIV-1 it wraps to 0 and idx advances 0→1→2→3→0.
- State per slot: GUARD while cnt<GUARD, else DRIVE. Frame = 4 slots = 4*REFRESH_DIV clocks.
- Output timing: all outputs are registered and reflect the cnt/idx of the previous cycle (1-cycle latency).
- GUARD: an=4'b1111, seg=7'b1111111.
- DRIVE:
  - an = all ones except bit idx = 0.
  - seg = decode(active digit idx), unless that digit is blanked.
- Decode, active-low, digit→seg:
  - 0→0000001, 1→1001111, 2→0010010, 3→0000110, 4→1001100.
  - 5→0100100, 6→0100000, 7→0001111, 8→0000000, 9→0001100.
  - 10–15 (non-BCD)→1111111; the anode is still driven.
- Leading-zero blanking, when blank_lz=1:
  - Digit i (i=3..1) is blanked if digits 3..i of active are all 0.
  - A blanked digit keeps an=1111 for its whole slot.
  - Digit0 is never blanked, so value 0 shows a single "0".
- Load and commit:
  - load=1 writes pend_val<=value and sets pending=1.
  - A load while pending=1 overwrites pend_val; the last load wins.
- Frame boundary is the cycle with idx==3 and cnt==REFRESH_DIV-1. On that cycle:
  - If pending: active<=pend_val and pending<=0.
  - If load is also high on that cycle: active<=value directly and pending stays 0.
  - frame_done=1 on the following cycle, for exactly one cycle.
- active never changes mid-frame.
- blank_lz is sampled continuously; a change takes effect on the next DRIVE cycle.
- Reset mid-frame: all state returns to reset values immediately (async); any pending load is discarded.

Test Plan:
- Reset/idle: REFRESH_DIV=8, GUARD=2, hold rst 3 cycles → an=1111 and seg=1111111 during reset. After release, first DRIVE shows digit0 with an=1110, seg=0000001. frame_done pulses every 32 clocks.
- Scan order: load 16'h1234, wait one boundary → per slot an=1110/seg=1001100 ("4"), 1101/0000110, 1011/0010010, 0111/1001111. Each slot has 2 guard cycles at an=1111.
- Deferred commit: load 16'h5678 mid-frame while showing 16'h1234 → pending=1 and the display stays 1234 until the boundary. From the next frame it shows 5678 and pending=0.
- Overwrite/boundary race: load 16'h1111 mid-frame, then 16'h2222 on the exact boundary cycle → the next frame shows 2222 and pending=0. 1111 is never displayed.
- Blanking:
  - value=16'h0070 with blank_lz=1 → digit3/digit2 slots keep an=1111; digit1 shows 0001111, digit0 shows 0000001.
  - value=0 → only digit0 is lit.
  - value=16'h00A5 → digit1's anode is driven with seg=1111111.
- Async reset mid-frame: assert rst at idx=2 with pending=1 → an=1111 within the same cycle. After release the display shows 0 and pending=0.
